// File: rtl/buzzer_sched_if.sv
// buzzer_sched_if: request/grant bundle between alert sources and the buzzer
// beep-sequence scheduler. The master side is the requesters, the slave side
// is the scheduler.
interface buzzer_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_tone;
  logic [4*NREQ-1:0] req_cnt;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        mode;

  modport master (
    output req, req_tone, req_cnt,
    input  grant, done, busy, mode
  );

  modport slave (
    input  req, req_tone, req_cnt,
    output grant, done, busy, mode
  );
endinterface

// File: rtl/buzzer_sched.sv
// buzzer_sched: shares one buzzer tone generator between NREQ alert sources.
// Fixed-priority arbitration (index 0 highest), then ON/OFF phases per beep,
// a trailing GAP, and a one-cycle FIN that produces the done pulse.
// Optional build macro: BUZZER_SCHED_PREEMPT_EN (a higher-priority request
// aborts a running sequence during ON/OFF/GAP).
module buzzer_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_TICKS  = 200,
  parameter int unsigned OFF_TICKS = 100,
  parameter int unsigned GAP_TICKS = 300
) (
  input  logic           clk,
  input  logic           RSTn,
  buzzer_sched_if.slave  bus
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned PH_MAX =
    (ON_TICKS > OFF_TICKS) ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                           : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(GAP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, ON, OFF, GAP, FIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        tone_q;
  logic [3:0]        beeps_q;
  logic [TICK_W-1:0] tick_q;
  logic [PH_W-1:0]   phase_q;

  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [7:0]        mode_q, mode_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [1:0]        pick_tone;
  logic [3:0]        pick_cnt;
  logic              arb_ok;

  logic [PH_W-1:0]   ph_last;
  logic              tick;
  logic              phase_end;
  logic              timed_q, timed_d;

  logic [IDX_W-1:0]  idx_d;
  logic [1:0]        tone_d;

  // Fixed-priority pick of the lowest set request and its configuration.
  // The done pulse doubles as a one-cycle cooldown after a completed sequence.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_tone = '0;
    pick_cnt  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req[i] && !pick_vld) begin
        pick_vld  = 1'b1;
        pick_idx  = IDX_W'(i);
        pick_tone = bus.req_tone[2*i +: 2];
        pick_cnt  = bus.req_cnt[4*i +: 4];
      end
    end
    arb_ok = (state_q == IDLE) && pick_vld && !(|done_q);
  end

`ifdef BUZZER_SCHED_PREEMPT_EN
  logic higher_req;

  // Any pending request with strictly higher priority than the granted source.
  always_comb begin
    higher_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req[i] && (i < 32'(idx_q)))
        higher_req = 1'b1;
    end
  end
`endif

  // Tick and phase-length decode for the timed states.
  always_comb begin
    case (state_q)
      ON:      ph_last = ON_LAST;
      OFF:     ph_last = OFF_LAST;
      GAP:     ph_last = GAP_LAST;
      default: ph_last = '0;
    endcase
    timed_q   = (state_q == ON) || (state_q == OFF) || (state_q == GAP);
    timed_d   = (state_d == ON) || (state_d == OFF) || (state_d == GAP);
    tick      = timed_q && (tick_q == TICK_LAST);
    phase_end = tick && (phase_q == ph_last);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arb_ok) state_d = (pick_cnt != 4'd0) ? ON : FIN;
      ON:   if (phase_end) state_d = (beeps_q == 4'd1) ? GAP : OFF;
      OFF:  if (phase_end) state_d = ON;
      GAP:  if (phase_end) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BUZZER_SCHED_PREEMPT_EN
    if (timed_q && higher_req)
      state_d = IDLE;
`endif
  end

  // Next values of the registered outputs, decoded from the state being entered.
  always_comb begin
    idx_d   = (state_q == IDLE) ? pick_idx  : idx_q;
    tone_d  = (state_q == IDLE) ? pick_tone : tone_q;
    grant_d = '0;
    done_d  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if ((state_d != IDLE) && (32'(idx_d) == i)) grant_d[i] = 1'b1;
      if ((state_q == FIN)  && (32'(idx_q) == i)) done_d[i]  = 1'b1;
    end
    busy_d = (state_d != IDLE);
    mode_d = (state_d == ON) ? {6'b0, tone_d} : 8'h00;
  end

  // State register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latched request, beep/tick/phase counters and registered outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      idx_q   <= '0;
      tone_q  <= '0;
      beeps_q <= '0;
      tick_q  <= '0;
      phase_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      mode_q  <= 8'h00;
    end else begin
      if (arb_ok) begin
        idx_q   <= pick_idx;
        tone_q  <= pick_tone;
        beeps_q <= pick_cnt;
      end else if ((state_q == ON) && phase_end) begin
        beeps_q <= beeps_q - 4'd1;
      end

      if ((state_d != state_q) || !timed_d) begin
        tick_q  <= '0;
        phase_q <= '0;
      end else if (tick) begin
        tick_q  <= '0;
        phase_q <= phase_q + PH_W'(1);
      end else begin
        tick_q  <= tick_q + TICK_W'(1);
      end

      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.mode  = mode_q;

endmodule
